// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

   // Width of the latency and starvation counters; bounds both to 1..15.
   localparam int CNT_W = 4;

   // Access sequencing: accept in IDLE, strobe in ISSUE, wait out the
   // memory latency, then pulse the response.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   // Requester that owns the access in flight.
   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection between fetch and data requesters, with a saturating
// starvation counter that forces fetch to win after STARVE_MAX losses.
module mem_arb_select
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic idle,
   input  logic ireq_valid,
   input  logic dreq_valid,
   output logic grant_i,
   output logic grant_d
);

   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;

   // Data has priority unless fetch has already lost STARVE_MAX times in a row.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (idle) begin
         grant_i = ireq_valid && (!dreq_valid || (starve_cnt == STARVE_LIM));
         grant_d = dreq_valid && !grant_i;
      end
   end

   // Count consecutive lost arbitrations for fetch; only IDLE cycles count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         starve_cnt <= '0;
      end else if (idle) begin
         if (!ireq_valid || grant_i) begin
            starve_cnt <= '0;
         end else if (grant_d && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between the instruction fetch
// and data requesters. One access in flight; each access gets exactly one
// mem_en strobe and one response pulse to its owner.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 64,
   parameter int MEM_LATENCY = 2,
   parameter int STARVE_MAX  = 4
) (
   input  logic              clk,
   input  logic              reset,
   // fetch requester
   input  logic              ireq_valid,
   input  logic [ADDR_W-1:0] ireq_addr,
   output logic              ireq_ready,
   output logic              irsp_valid,
   output logic [DATA_W-1:0] irsp_data,
   // data requester
   input  logic              dreq_valid,
   input  logic              dreq_we,
   input  logic [ADDR_W-1:0] dreq_addr,
   input  logic [DATA_W-1:0] dreq_wdata,
   output logic              dreq_ready,
   output logic              drsp_valid,
   output logic [DATA_W-1:0] drsp_data,
   // memory side
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   // status
   output logic              busy
);

   // Counter load value in ISSUE so that the WAIT count reaches zero in the
   // cycle mem_rdata becomes valid.
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

   arb_state_t       state;
   arb_state_t       next_state;
   req_id_t          owner;
   logic             lat_we;
   logic [CNT_W-1:0] lat_cnt;
   logic             idle;
   logic             grant_i;
   logic             grant_d;
   logic             accept;
   logic             capture;

   // Readies are held low during reset even though the state already reads IDLE.
   assign idle    = (state == IDLE) && reset;
   assign accept  = grant_i || grant_d;
   assign capture = (state == WAIT) && (lat_cnt == '0) && !lat_we;

   mem_arb_select #(
      .STARVE_MAX (STARVE_MAX)
   ) u_select (
      .clk        (clk),
      .reset      (reset),
      .idle       (idle),
      .ireq_valid (ireq_valid),
      .dreq_valid (dreq_valid),
      .grant_i    (grant_i),
      .grant_d    (grant_d)
   );

   assign ireq_ready = grant_i;
   assign dreq_ready = grant_d;
   assign busy       = (state != IDLE);
   assign irsp_valid = (state == RESP) && (owner == REQ_I);
   assign drsp_valid = (state == RESP) && (owner == REQ_D);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: one pass IDLE -> ISSUE -> WAIT -> RESP -> IDLE per access.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (accept) next_state = ISSUE;
         ISSUE:   next_state = WAIT;
         WAIT:    if (lat_cnt == '0) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Latch the winning request; the memory-side outputs are these registers,
   // so mem_en is high only in the ISSUE cycle that follows an accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the address/data registers are reset too because every output must read 0 in reset.
         owner     <= REQ_D;
         lat_we    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= accept;
         mem_we <= grant_d && dreq_we;
         if (accept) begin
            owner     <= grant_i ? REQ_I : REQ_D;
            lat_we    <= grant_d && dreq_we;
            mem_addr  <= grant_i ? ireq_addr : dreq_addr;
            mem_wdata <= grant_d ? dreq_wdata : '0;
         end
      end
   end

   // Latency counter: loaded in ISSUE, counts down to zero in WAIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_cnt <= '0;
      end else if (state == ISSUE) begin
         lat_cnt <= LAT_LOAD;
      end else if ((state == WAIT) && (lat_cnt != '0)) begin
         lat_cnt <= lat_cnt - 1'b1;
      end
   end

   // Capture read data into the owner's response register; stores leave it untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irsp_data <= '0;
         drsp_data <= '0;
      end else if (capture) begin
         if (owner == REQ_I) begin
            irsp_data <= mem_rdata;
         end else begin
            drsp_data <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic, compared against a transaction-level model kept in cycle numbers.
module tb_mem_port_arbiter;

   localparam int LAT  = 2;
   localparam int SMAX = 4;
   localparam logic [63:0] LAT_RDATA = 64'hC0FF_EE00_1234_5678;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ireq_valid, dreq_valid, dreq_we;
   logic [31:0] ireq_addr, dreq_addr;
   logic [63:0] dreq_wdata, mem_rdata;
   logic        ireq_ready, irsp_valid, dreq_ready, drsp_valid;
   logic        mem_en, mem_we, busy;
   logic [63:0] irsp_data, drsp_data, mem_wdata;
   logic [31:0] mem_addr;

   // outputs of the latency-sweep instances (index 0: latency 1, index 1: latency 7)
   logic        x_ireq_ready [2];
   logic        x_irsp_valid [2];
   logic [63:0] x_irsp_data  [2];
   logic        x_dreq_ready [2];
   logic        x_drsp_valid [2];
   logic [63:0] x_drsp_data  [2];
   logic        x_mem_en     [2];
   logic        x_mem_we     [2];
   logic [31:0] x_mem_addr   [2];
   logic [63:0] x_mem_wdata  [2];
   logic        x_busy       [2];

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset(reset),
      .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
      .irsp_valid(irsp_valid), .irsp_data(irsp_data),
      .dreq_valid(dreq_valid), .dreq_we(dreq_we), .dreq_addr(dreq_addr),
      .dreq_wdata(dreq_wdata), .dreq_ready(dreq_ready),
      .drsp_valid(drsp_valid), .drsp_data(drsp_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   for (genvar g = 0; g < 2; g++) begin : g_lat
      mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LATENCY(g == 0 ? 1 : 7), .STARVE_MAX(SMAX)) u_x (
         .clk(clk), .reset(reset),
         .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(x_ireq_ready[g]),
         .irsp_valid(x_irsp_valid[g]), .irsp_data(x_irsp_data[g]),
         .dreq_valid(dreq_valid), .dreq_we(dreq_we), .dreq_addr(dreq_addr),
         .dreq_wdata(dreq_wdata), .dreq_ready(x_dreq_ready[g]),
         .drsp_valid(x_drsp_valid[g]), .drsp_data(x_drsp_data[g]),
         .mem_en(x_mem_en[g]), .mem_we(x_mem_we[g]), .mem_addr(x_mem_addr[g]),
         .mem_wdata(x_mem_wdata[g]), .mem_rdata(LAT_RDATA), .busy(x_busy[g])
      );
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- memories: the one the DUT talks to, and the model's view
   logic [63:0] phys_mem [logic [31:0]];
   logic [63:0] ref_mem  [logic [31:0]];

   function automatic logic [63:0] mem_init(input logic [31:0] a);
      return {~a, a ^ 32'h5A5A_0000};
   endfunction

   function automatic logic [63:0] phys_rd(input logic [31:0] a);
      return phys_mem.exists(a) ? phys_mem[a] : mem_init(a);
   endfunction

   function automatic logic [63:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Synchronous memory: data valid only in the cycle LAT after the mem_en
   // cycle, random garbage at all other times.
   int          rd_cnt = 0;
   logic [63:0] rd_val = '0;
   initial begin
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rd_cnt > 0) begin
            rd_cnt--;
            mem_rdata = (rd_cnt == 0) ? rd_val : rnd64();
         end else begin
            mem_rdata = rnd64();
         end
         @(negedge clk);
         if (reset && mem_en) begin
            rd_val = phys_rd(mem_addr);
            if (mem_we) phys_mem[mem_addr] = mem_wdata;
            rd_cnt = LAT;
         end
      end
   end

   // ---------------- transaction-level reference model (times in cycle numbers)
   int          cyc = 0;
   bit          pend = 1'b0;
   int          acc_cyc = 0;
   bit          acc_d = 1'b0;
   bit          acc_we = 1'b0;
   logic [31:0] acc_addr = '0;
   logic [63:0] acc_wdata = '0;
   logic [63:0] acc_rdata = '0;
   logic [63:0] exp_idata = '0;
   logic [63:0] exp_ddata = '0;
   int          starve = 0;
   bit          obs_ir, obs_dr;

   // Drive one cycle of requester inputs and check every DUT output in that cycle.
   task automatic step(input bit iv, input logic [31:0] ia, input bit dv, input bit dwe,
                       input logic [31:0] da, input logic [63:0] dw);
      bit gi, gd, idle, en_now, rsp_now;
      @(posedge clk);
      #1;
      cyc++;
      ireq_valid = iv; ireq_addr = ia;
      dreq_valid = dv; dreq_we = dwe; dreq_addr = da; dreq_wdata = dw;
      @(negedge clk);
      if (pend && (cyc >= acc_cyc + LAT + 3)) pend = 1'b0;
      idle    = !pend;
      en_now  = pend && (cyc == acc_cyc + 1);
      rsp_now = pend && (cyc == acc_cyc + LAT + 2);
      check("busy", busy, !idle);
      check("mem_en", mem_en, en_now);
      if (en_now) begin
         check("mem_we", mem_we, acc_we);
         check("mem_addr", mem_addr, acc_addr);
         if (acc_we) check("mem_wdata", mem_wdata, acc_wdata);
      end
      if (rsp_now && !acc_d) exp_idata = acc_rdata;
      if (rsp_now && acc_d && !acc_we) exp_ddata = acc_rdata;
      check("irsp_valid", irsp_valid, rsp_now && !acc_d);
      check("drsp_valid", drsp_valid, rsp_now && acc_d);
      check("irsp_data", irsp_data, exp_idata);
      check("drsp_data", drsp_data, exp_ddata);
      gi = idle && iv && (!dv || starve == SMAX);
      gd = idle && dv && !gi;
      check("ireq_ready", ireq_ready, gi);
      check("dreq_ready", dreq_ready, gd);
      obs_ir = ireq_ready;
      obs_dr = dreq_ready;
      if (idle) begin
         if (!iv || gi) starve = 0;
         else if (starve < SMAX) starve++;
      end
      if (gi || gd) begin
         pend      = 1'b1;
         acc_cyc   = cyc;
         acc_d     = gd;
         acc_we    = gd && dwe;
         acc_addr  = gi ? ia : da;
         acc_wdata = dw;
         if (acc_we) ref_mem[da] = dw;
         else acc_rdata = ref_rd(acc_addr);
      end
   endtask

   task automatic idle_steps(input int n);
      for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_en"}, mem_en, 1'b0);
      check({tag, "_mem_we"}, mem_we, 1'b0);
      check({tag, "_mem_addr"}, mem_addr, '0);
      check({tag, "_mem_wdata"}, mem_wdata, '0);
      check({tag, "_ireq_ready"}, ireq_ready, 1'b0);
      check({tag, "_dreq_ready"}, dreq_ready, 1'b0);
      check({tag, "_irsp_valid"}, irsp_valid, 1'b0);
      check({tag, "_drsp_valid"}, drsp_valid, 1'b0);
      check({tag, "_irsp_data"}, irsp_data, '0);
      check({tag, "_drsp_data"}, drsp_data, '0);
      check({tag, "_busy"}, busy, 1'b0);
   endtask

   // random requester state
   bit          ip = 1'b0, dp = 1'b0, dwe_r = 1'b0;
   logic [31:0] ia_r = '0, da_r = '0;
   logic [63:0] dw_r = '0;

   initial begin
      int t0, main_rsp, acc_at, n_acc, first_i, second_i, pulses;
      int x_en_cnt [2];
      int x_rsp_at [2];

      ireq_valid = 1'b0; ireq_addr = '0;
      dreq_valid = 1'b0; dreq_we = 1'b0; dreq_addr = '0; dreq_wdata = '0;
      phys_mem[32'h100] = 64'hDEAD_BEEF;
      ref_mem[32'h100]  = 64'hDEAD_BEEF;

      // reset state, with both requesters asserting valid
      #12;
      ireq_valid = 1'b1;
      dreq_valid = 1'b1;
      #1;
      check_all_zero("reset");
      ireq_valid = 1'b0;
      dreq_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // single fetch, also run by the latency-1 and latency-7 instances
      step(1'b1, 32'h100, 1'b0, 1'b0, '0, '0);
      t0 = cyc;
      check("fetch_accept", obs_ir, 1'b1);
      main_rsp = -1;
      for (int g = 0; g < 2; g++) begin x_en_cnt[g] = 0; x_rsp_at[g] = -1; end
      for (int k = 0; k < 11; k++) begin
         step(1'b0, '0, 1'b0, 1'b0, '0, '0);
         if (irsp_valid) main_rsp = cyc;
         for (int g = 0; g < 2; g++) begin
            if (x_mem_en[g]) x_en_cnt[g]++;
            if (x_irsp_valid[g]) x_rsp_at[g] = cyc;
         end
      end
      check("fetch_rsp_cycle", main_rsp - t0, 4);
      check("fetch_data", irsp_data, 64'hDEAD_BEEF);
      check("lat1_rsp_cycle", x_rsp_at[0] - t0, 3);
      check("lat7_rsp_cycle", x_rsp_at[1] - t0, 9);
      check("lat1_mem_en_pulses", x_en_cnt[0], 1);
      check("lat7_mem_en_pulses", x_en_cnt[1], 1);
      check("lat1_data", x_irsp_data[0], LAT_RDATA);
      check("lat7_data", x_irsp_data[1], LAT_RDATA);

      // store then load at the same address
      step(1'b0, '0, 1'b1, 1'b1, 32'h40, 64'h1234);
      check("store_accept", obs_dr, 1'b1);
      idle_steps(5);
      step(1'b0, '0, 1'b1, 1'b0, 32'h40, '0);
      check("load_accept", obs_dr, 1'b1);
      idle_steps(5);
      check("load_data", drsp_data, 64'h1234);

      // contention: data wins, fetch served at the next IDLE cycle
      step(1'b1, 32'h200, 1'b1, 1'b0, 32'h48, '0);
      t0 = cyc;
      check("contend_dready", obs_dr, 1'b1);
      check("contend_iready", obs_ir, 1'b0);
      acc_at = -1;
      for (int k = 0; k < 8 && acc_at < 0; k++) begin
         step(1'b1, 32'h200, 1'b0, 1'b0, '0, '0);
         if (obs_ir) acc_at = cyc;
      end
      check("contend_fetch_cycle", acc_at - t0, 5);
      idle_steps(6);

      // starvation: both held valid, fetch must win every fifth grant
      n_acc = 0; first_i = -1; second_i = -1;
      for (int k = 0; k < 120 && n_acc < 10; k++) begin
         step(1'b1, 32'h300, 1'b1, 1'b0, 32'h1000 + 32'(n_acc * 8), '0);
         if (obs_ir) begin
            if (first_i < 0) first_i = n_acc;
            else if (second_i < 0) second_i = n_acc;
         end
         if (obs_ir || obs_dr) n_acc++;
      end
      check("starve_grants", n_acc, 10);
      check("starve_first_fetch", first_i, 4);
      check("starve_second_fetch", second_i, 9);
      idle_steps(6);

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1'b1;
            ia_r = 32'h1000 + ($urandom_range(0, 15) << 3);
         end else if (ip && $urandom_range(0, 31) == 0) begin
            ip = 1'b0;
         end
         if (!dp && $urandom_range(0, 1) == 0) begin
            dp = 1'b1;
            dwe_r = 1'($urandom_range(0, 1));
            da_r = 32'h1000 + ($urandom_range(0, 15) << 3);
            dw_r = rnd64();
         end else if (dp && $urandom_range(0, 31) == 0) begin
            dp = 1'b0;
         end
         step(ip, ia_r, dp, dwe_r, da_r, dw_r);
         if (obs_ir) ip = 1'b0;
         if (obs_dr) dp = 1'b0;
      end
      idle_steps(8);

      // reset in the middle of WAIT aborts the access with no response
      step(1'b1, 32'h340, 1'b0, 1'b0, '0, '0);
      check("abort_accept", obs_ir, 1'b1);
      idle_steps(2);
      #2;
      reset = 1'b0;
      ireq_valid = 1'b1;
      dreq_valid = 1'b1;
      #1;
      check_all_zero("abort");
      pend = 1'b0; starve = 0; exp_idata = '0; exp_ddata = '0;
      ireq_valid = 1'b0;
      dreq_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         step(1'b0, '0, 1'b0, 1'b0, '0, '0);
         if (irsp_valid || drsp_valid) pulses++;
      end
      check("abort_no_pulse", pulses, 0);
      step(1'b1, 32'h100, 1'b0, 1'b0, '0, '0);
      check("after_abort_accept", obs_ir, 1'b1);
      idle_steps(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the instruction-fetch requester (IMemRead/IRWrite path) and the data requester (DMemOp/LoadMDR path) of the multicycle core.
- Uses a valid/ready request handshake and returns one response pulse per access, so the control FSM can stall on memory instead of assuming fixed timing.
- Only one access is outstanding at a time.
- Priority goes to data, with a starvation guard for fetch.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 64, memory word width; both requesters see the full word.
- MEM_LATENCY, 2, cycles from the mem_en cycle to mem_rdata valid; legal range is 1..15.
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch is forced to win; legal range is 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ireq_valid  in  1  fetch request.
- ireq_addr  in  ADDR_W  fetch address.
- ireq_ready  out  1  fetch request accepted this cycle.
- irsp_valid  out  1  one-cycle pulse: fetch data valid.
- irsp_data  out  DATA_W  fetch read data.
- dreq_valid  in  1  data request.
- dreq_we  in  1  1 = store, 0 = load.
- dreq_addr  in  ADDR_W  data address.
- dreq_wdata  in  DATA_W  store data.
- dreq_ready  out  1  data request accepted this cycle.
- drsp_valid  out  1  one-cycle pulse: load data valid, or store complete.
- drsp_data  out  DATA_W  load data; holds the last value after a store.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0: mem_*, *_ready, *_rsp_valid, *_rsp_data, busy.
  - Latency counter=0, starve counter=0, owner=REQ_D.
- States:
  - IDLE: ready outputs are combinational and only asserted in IDLE.
  - ISSUE: mem_en=1 for exactly this one cycle.
  - WAIT: counts MEM_LATENCY cycles.
  - RESP: response pulse, then return to IDLE.
- Arbitration in IDLE (at most one ready per cycle):
  - Fetch wins (ireq_ready=1) if ireq_valid && (!dreq_valid || starve_cnt==STARVE_MAX).
  - Otherwise dreq_ready = dreq_valid.
- Starvation counter:
  - starve_cnt increments, saturating at STARVE_MAX, on each IDLE cycle where ireq_valid && dreq wins.
  - Clears on a fetch grant or when ireq_valid=0.
- Accept at cycle T (valid && ready):
  - Latch owner, addr, we and wdata (we forced to 0 for fetch).
  - Next state ISSUE.
- ISSUE, cycle T+1:
  - mem_en=1; mem_we/mem_addr/mem_wdata come from the latched registers (registered outputs).
  - Latency counter loads MEM_LATENCY-1; next state WAIT.
- WAIT:
  - Decrement each cycle; at 0, capture mem_rdata (cycle T+1+MEM_LATENCY) into the owner's rsp_data register, unless the access is a store.
  - Next state RESP.
- RESP, cycle T+2+MEM_LATENCY:
  - Owner's rsp_valid=1 for one cycle; next state IDLE.
  - The new request is accepted no earlier than T+3+MEM_LATENCY.
  - Peak rate is one access per MEM_LATENCY+3 cycles.
- Address handling: addresses pass through unmodified; no alignment check.
- Requester rules:
  - A requester must hold valid, addr, we and wdata stable until ready.
  - Deasserting valid before ready is legal and has no effect.
  - Inputs are ignored outside IDLE.
- Simultaneous ireq and dreq in IDLE: data wins unless the starvation limit is reached; the loser keeps valid and is served on a later IDLE cycle.
- Reset mid-access: the access is aborted, no response pulse, and a store is not guaranteed written.
- rsp_data registers hold their value until the next capture for the same owner.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, ISSUE, WAIT, RESP};
  - typedef enum req_id_t {REQ_I, REQ_D};
  - localparam CNT_W=4.
- Sub-module mem_arb_select: winner selection plus the saturating starvation counter.
  - Inputs: clk, reset, idle, ireq_valid, dreq_valid.
  - Outputs: grant_i, grant_d.
- The top level holds the FSM, latch registers and response logic.

Test Plan:
- Single fetch: ireq addr=0x100, mem returns 0xDEADBEEF at T+3 → mem_en at T+1 with addr 0x100, we=0; irsp_valid at T+4 with data 0xDEADBEEF; busy high T+1..T+4.
- Store then load: dreq we=1 addr=0x40 wdata=0x1234 → mem_en&&mem_we at T+1, drsp_valid at T+4; then a load at 0x40 returns 0x1234 on drsp_data.
- Contention: ireq and dreq both valid in the same IDLE cycle → dreq_ready=1, ireq_ready=0; fetch is accepted in the next IDLE cycle (T+5).
- Starvation: dreq held continuously valid with ireq valid, STARVE_MAX=4 → four data grants, then the fifth grant goes to fetch; starve_cnt returns to 0.
- Reset mid-access: assert reset=0 during WAIT → all outputs 0 immediately, no irsp/drsp pulse after release, state IDLE.
- Latency sweep: MEM_LATENCY=1 and 7 → rsp_valid at T+3 and T+9 respectively; exactly one mem_en pulse per access.
